ac_param: RTL and testbench

Parametrised successor to the lab accumulator: a WIDTH-bit accumulator register with an opcode-driven datapath (load, add, subtract, clear, logic ops), status flags, optional signed saturation and a DEPTH-entry undo history. It sits between the switch/bus input Z and the display or bus consumer of AC, and drops into the board top level in place of the single-function LOAD_AC accumulator.

---
 rtl/ac_param.sv | 156 +++++++++++++++
 tb/tb_ac_param.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ac_param.sv
// Parametrised accumulator with an opcode datapath, status flags, optional signed
// saturation and a circular LIFO undo history of the last DEPTH pre-op values.
module ac_param #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int SAT   = 0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       op_valid,
  input  logic [2:0]                 op,
  input  logic [WIDTH-1:0]           Z,
  output logic [WIDTH-1:0]           AC,
  output logic                       carry,
  output logic                       overflow,
  output logic                       zero,
  output logic                       negative,
  output logic [$clog2(DEPTH+1)-1:0] hist_count,
  output logic                       err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_CLR  = 3'b100;
  localparam logic [2:0] OP_UNDO = 3'b101;
  localparam logic [2:0] OP_AND  = 3'b110;
  localparam logic [2:0] OP_OR   = 3'b111;

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0]    LAST_C  = PW'(DEPTH - 1);

  logic [WIDTH-1:0] ac_r;
  logic             carry_r;
  logic             ovf_r;
  logic             err_r;
  logic [CW-1:0]    cnt_r;
  logic [PW-1:0]    wp_r;
  logic [WIDTH-1:0] hist_r [DEPTH];

  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   diff_s;
  logic             add_ovf_s;
  logic             sub_ovf_s;
  logic [WIDTH-1:0] sat_val_s;
  logic [PW-1:0]    wp_inc_s;
  logic [PW-1:0]    wp_dec_s;
  logic [WIDTH-1:0] ac_n_s;
  logic             carry_n_s;
  logic             ovf_n_s;
  logic             err_n_s;
  logic             push_s;
  logic             pop_s;

  assign sum_s     = {1'b0, ac_r} + {1'b0, Z};
  assign diff_s    = {1'b0, ac_r} - {1'b0, Z};
  assign add_ovf_s = (ac_r[WIDTH-1] == Z[WIDTH-1]) && (sum_s[WIDTH-1] != ac_r[WIDTH-1]);
  assign sub_ovf_s = (ac_r[WIDTH-1] != Z[WIDTH-1]) && (diff_s[WIDTH-1] != ac_r[WIDTH-1]);
  // Overflow always points away from AC's sign, so AC's sign picks the clamp value.
  assign sat_val_s = ac_r[WIDTH-1] ? MAX_NEG : MAX_POS;
  assign wp_inc_s  = (wp_r == LAST_C) ? {PW{1'b0}} : (wp_r + PW'(1));
  assign wp_dec_s  = (wp_r == {PW{1'b0}}) ? LAST_C : (wp_r - PW'(1));

  // Next accumulator, flags and history action for the sampled op.
  always_comb begin
    ac_n_s    = ac_r;
    carry_n_s = carry_r;
    ovf_n_s   = ovf_r;
    err_n_s   = 1'b0;
    push_s    = 1'b0;
    pop_s     = 1'b0;
    if (op_valid) begin
      case (op)
        OP_LOAD: begin
          ac_n_s = Z; carry_n_s = 1'b0; ovf_n_s = 1'b0; push_s = 1'b1;
        end
        OP_ADD: begin
          carry_n_s = sum_s[WIDTH];
          ovf_n_s   = add_ovf_s;
          ac_n_s    = ((SAT != 0) && add_ovf_s) ? sat_val_s : sum_s[WIDTH-1:0];
          push_s    = 1'b1;
        end
        OP_SUB: begin
          carry_n_s = diff_s[WIDTH];
          ovf_n_s   = sub_ovf_s;
          ac_n_s    = ((SAT != 0) && sub_ovf_s) ? sat_val_s : diff_s[WIDTH-1:0];
          push_s    = 1'b1;
        end
        OP_CLR: begin
          ac_n_s = {WIDTH{1'b0}}; carry_n_s = 1'b0; ovf_n_s = 1'b0; push_s = 1'b1;
        end
        OP_AND: begin
          ac_n_s = ac_r & Z; carry_n_s = 1'b0; ovf_n_s = 1'b0; push_s = 1'b1;
        end
        OP_OR: begin
          ac_n_s = ac_r | Z; carry_n_s = 1'b0; ovf_n_s = 1'b0; push_s = 1'b1;
        end
        OP_UNDO: begin
          if (cnt_r != {CW{1'b0}}) begin
            ac_n_s = hist_r[wp_dec_s]; carry_n_s = 1'b0; ovf_n_s = 1'b0; pop_s = 1'b1;
          end else begin
            err_n_s = 1'b1;
          end
        end
        OP_NOP:  begin end
        default: begin end
      endcase
    end else begin
      err_n_s = 1'b0;
    end
  end

  // State update; the write pointer wraps so a full history overwrites its oldest entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ac_r    <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      ovf_r   <= 1'b0;
      err_r   <= 1'b0;
      cnt_r   <= {CW{1'b0}};
      wp_r    <= {PW{1'b0}};
      for (int i = 0; i < DEPTH; i++) hist_r[i] <= {WIDTH{1'b0}};
    end else begin
      ac_r    <= ac_n_s;
      carry_r <= carry_n_s;
      ovf_r   <= ovf_n_s;
      err_r   <= err_n_s;
      if (push_s) begin
        hist_r[wp_r] <= ac_r;
        wp_r         <= wp_inc_s;
        cnt_r        <= (cnt_r == DEPTH_C) ? cnt_r : (cnt_r + CW'(1));
      end else if (pop_s) begin
        wp_r  <= wp_dec_s;
        cnt_r <= cnt_r - CW'(1);
      end else begin
        wp_r  <= wp_r;
        cnt_r <= cnt_r;
      end
    end
  end

  assign AC         = ac_r;
  assign carry      = carry_r;
  assign overflow   = ovf_r;
  assign err        = err_r;
  assign hist_count = cnt_r;
  assign zero       = (ac_r == {WIDTH{1'b0}});
  assign negative   = ac_r[WIDTH-1];

endmodule

// File: tb/tb_ac_param.sv
// Directed bench for ac_param: a wrapping (SAT=0) and a saturating (SAT=1) instance
// share the stimulus; a behavioural model feeds a scoreboard queue per op.
module tb_ac_param;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         op_valid = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] Z = 8'h00;

  logic [W-1:0] ac0, ac1;
  logic         c0, c1, v0, v1, zr0, zr1, ng0, ng1, e0, e1;
  logic [2:0]   n0, n1;

  int evals = 0;
  int fails = 0;

  ac_param #(.WIDTH(W), .DEPTH(D), .SAT(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op(op), .Z(Z),
    .AC(ac0), .carry(c0), .overflow(v0), .zero(zr0), .negative(ng0),
    .hist_count(n0), .err(e0));

  ac_param #(.WIDTH(W), .DEPTH(D), .SAT(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op(op), .Z(Z),
    .AC(ac1), .carry(c1), .overflow(v1), .zero(zr1), .negative(ng1),
    .hist_count(n1), .err(e1));

  always #5 clk = ~clk;

  typedef struct {
    int         k;
    logic [7:0] ac;
    logic       c, v, e;
    logic [2:0] n;
  } exp_t;

  exp_t sb[$];

  logic [7:0] m_ac [2];
  logic       m_c  [2];
  logic       m_v  [2];
  logic       m_e  [2];
  logic [7:0] m_h  [2][D];
  int         m_n  [2];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    evals++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ac[k] = 8'h00; m_c[k] = 1'b0; m_v[k] = 1'b0; m_e[k] = 1'b0; m_n[k] = 0;
    end
  endtask

  // History kept oldest-first; a full stack drops index 0.
  task automatic m_push(input int k);
    if (m_n[k] == D) begin
      for (int i = 0; i < D - 1; i++) m_h[k][i] = m_h[k][i+1];
      m_h[k][D-1] = m_ac[k];
    end else begin
      m_h[k][m_n[k]] = m_ac[k];
      m_n[k]++;
    end
  endtask

  task automatic model_op(input int k, input logic v, input logic [2:0] o, input logic [7:0] z);
    int a, b, s, u;
    m_e[k] = 1'b0;
    if (!v) return;
    a = int'($signed(m_ac[k]));
    b = int'($signed(z));
    case (o)
      3'd1: begin m_push(k); m_ac[k] = z; m_c[k] = 1'b0; m_v[k] = 1'b0; end
      3'd2, 3'd3: begin
        m_push(k);
        if (o == 3'd2) begin
          s = a + b; u = int'(m_ac[k]) + int'(z); m_c[k] = (u > 255);
        end else begin
          s = a - b; u = int'(m_ac[k]) - int'(z); m_c[k] = (z > m_ac[k]);
        end
        m_v[k] = (s > 127) || (s < -128);
        if (k == 1 && m_v[k]) m_ac[k] = (s > 127) ? 8'h7F : 8'h80;
        else                  m_ac[k] = u[7:0];
      end
      3'd4: begin m_push(k); m_ac[k] = 8'h00; m_c[k] = 1'b0; m_v[k] = 1'b0; end
      3'd5: begin
        if (m_n[k] > 0) begin
          m_n[k]--; m_ac[k] = m_h[k][m_n[k]]; m_c[k] = 1'b0; m_v[k] = 1'b0;
        end else begin
          m_e[k] = 1'b1;
        end
      end
      3'd6: begin m_push(k); m_ac[k] = m_ac[k] & z; m_c[k] = 1'b0; m_v[k] = 1'b0; end
      3'd7: begin m_push(k); m_ac[k] = m_ac[k] | z; m_c[k] = 1'b0; m_v[k] = 1'b0; end
      default: ;
    endcase
  endtask

  task automatic compare_one(input string tag, input exp_t x);
    string p;
    p = $sformatf("%s/sat%0d", tag, x.k);
    check({p, " AC"},       (x.k == 1) ? ac1 : ac0, x.ac);
    check({p, " carry"},    (x.k == 1) ? c1  : c0,  x.c);
    check({p, " overflow"}, (x.k == 1) ? v1  : v0,  x.v);
    check({p, " zero"},     (x.k == 1) ? zr1 : zr0, (x.ac == 8'h00));
    check({p, " negative"}, (x.k == 1) ? ng1 : ng0, x.ac[7]);
    check({p, " hist"},     (x.k == 1) ? n1  : n0,  x.n);
    check({p, " err"},      (x.k == 1) ? e1  : e0,  x.e);
  endtask

  task automatic step(input string tag, input logic v, input logic [2:0] o, input logic [7:0] z);
    exp_t x;
    @(negedge clk);
    op_valid = v; op = o; Z = z;
    for (int k = 0; k < 2; k++) begin
      model_op(k, v, o, z);
      x.k = k; x.ac = m_ac[k]; x.c = m_c[k]; x.v = m_v[k]; x.e = m_e[k]; x.n = 3'(m_n[k]);
      sb.push_back(x);
    end
    @(posedge clk);
    #1;
    while (sb.size() > 0) compare_one(tag, sb.pop_front());
  endtask

  task automatic check_now(input string tag);
    exp_t x;
    for (int k = 0; k < 2; k++) begin
      x.k = k; x.ac = m_ac[k]; x.c = m_c[k]; x.v = m_v[k]; x.e = m_e[k]; x.n = 3'(m_n[k]);
      compare_one(tag, x);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #23;
    check_now("reset");
    @(negedge clk);
    reset_n = 1'b1;

    step("load5a", 1'b1, 3'd1, 8'h5A);
    step("load7f", 1'b1, 3'd1, 8'h7F);
    step("add01",  1'b1, 3'd2, 8'h01);
    step("sub81",  1'b1, 3'd3, 8'h81);
    step("load7f", 1'b1, 3'd1, 8'h7F);
    step("add10",  1'b1, 3'd2, 8'h10);
    step("load80", 1'b1, 3'd1, 8'h80);
    step("sub01",  1'b1, 3'd3, 8'h01);
    step("addff",  1'b1, 3'd2, 8'hFF);
    step("and0f",  1'b1, 3'd6, 8'h0F);
    step("orc0",   1'b1, 3'd7, 8'hC0);
    step("clr",    1'b1, 3'd4, 8'hAA);
    step("undo",   1'b1, 3'd5, 8'h00);

    for (int i = 1; i <= 6; i++) step("wrapload", 1'b1, 3'd1, 8'(i));
    for (int i = 0; i < 5; i++)  step("wrapundo", 1'b1, 3'd5, 8'h00);
    step("errclear", 1'b1, 3'd0, 8'h00);

    step("ld2", 1'b1, 3'd1, 8'h22);
    step("add_ov", 1'b1, 3'd2, 8'h70);
    for (int i = 0; i < 3; i++) step("gated", 1'b0, 3'd2, 8'h33);
    step("nop", 1'b1, 3'd0, 8'h33);

    step("ld10", 1'b1, 3'd1, 8'h10);
    step("ld20", 1'b1, 3'd1, 8'h20);
    step("ld40", 1'b1, 3'd1, 8'h40);
    #2;
    op_valid = 1'b0;
    reset_n  = 1'b0;
    model_reset();
    #1;
    check_now("asyncreset");
    @(negedge clk);
    reset_n = 1'b1;
    step("undo_empty", 1'b1, 3'd5, 8'h00);
    step("after_err",  1'b1, 3'd0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", evals, fails);
    $finish;
  end

endmodule
